l1d_downstream_responder: RTL and testbench
===========================================

L1D_DOWNSTREAM_RESPONDER -- requirements
Module: l1d_downstream_responder

Interface
REQ-001 Parameter MSHR_ID_W, default 4, width of the MSHR identifier carried by a miss request.
REQ-002 Parameter WAY_NUM, default 4, one-hot victim-way vector width.
REQ-003 Parameter PLD_W, default 8, width of the opaque scoreboard payload.
REQ-004 Parameter DEPTH, default 8, outstanding-request capacity; power of two, >=2.
REQ-005 Parameter LATENCY, default 10, fixed request-to-response latency in cycles; >=1.
REQ-006 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, reset; asynchronous and active-high.
REQ-008 Port req_valid, input, 1, the L1D presents a miss request.
REQ-009 Port req_ready, output, 1, the responder accepts a request this cycle.
REQ-010 Port req_mshr_id, input, MSHR_ID_W, identifier of the requesting MSHR.
REQ-011 Port req_way, input, WAY_NUM, one-hot way reserved for the refill.
REQ-012 Port req_pld, input, PLD_W, payload returned unchanged.
REQ-013 Port resp_valid, output, 1, refill response available.
REQ-014 Port resp_ready, input, 1, the L1D accepts the response.
REQ-015 Ports resp_mshr_id, resp_way and resp_pld, outputs, MSHR_ID_W/WAY_NUM/PLD_W, echoed request fields.
REQ-016 Port outstanding, output, clog2(DEPTH)+1, number of stored entries.
REQ-017 Port dup_err, output, 1, sticky flag for a duplicate-MSHR protocol violation.

Function
REQ-018 Request handshake: accept when req_valid and req_ready are both high at a rising edge.
REQ-019 req_ready SHALL be (outstanding < DEPTH), with no same-cycle bypass from a pop.
REQ-020 Storage: in-order circular FIFO with wrap-around read and write pointers.
- Each entry holds mshr_id, way, pld and a countdown counter.
REQ-021 On push, the entry counter is loaded with LATENCY-1.
- Every later cycle it decrements by 1 and saturates at 0.
- Each entry counts independently, including entries that are not at the head.
REQ-022 resp_valid SHALL be high exactly when the FIFO is non-empty and the head counter is 0.
- A request accepted at the edge ending cycle t makes resp_valid high no earlier than cycle t+LATENCY.
REQ-023 Response handshake: pop the head when resp_valid and resp_ready are both high at a rising edge.
- While resp_valid is high and resp_ready is low, resp_valid and the resp_* fields SHALL hold stable.
REQ-024 resp_* fields SHALL be driven by the head entry.
- When resp_valid is low they are don't-care, and the implementation drives zeros.
REQ-025 Responses SHALL return strictly in acceptance order.
REQ-026 Simultaneous push and pop: outstanding is unchanged and both pointers advance.
REQ-027 Push into an empty FIFO: the pushed entry becomes the head and follows REQ-022.
REQ-028 Per-MSHR tracking: a DEPTH-independent vector of 2^MSHR_ID_W busy bits.
- Bit set on push, cleared on pop of the matching mshr_id.
- If a pop and a push of the same mshr_id coincide, the bit ends set.
REQ-029 A push whose mshr_id busy bit is already set (and not cleared by a same-cycle pop) SHALL set dup_err.
- The request is still accepted.
- dup_err remains high until reset.
REQ-030 req_way not one-hot (zero or more than one bit) SHALL also set dup_err; the request is still accepted.

Reset
REQ-031 While rst is high, all of the following SHALL hold:
- pointers and outstanding are 0;
- all busy bits are clear;
- req_ready is 0 and resp_valid is 0;
- resp_* fields are 0 and dup_err is 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries immediately, with no response emitted.
REQ-033 On the first rising edge after rst deasserts, req_ready SHALL be 1.

Verification
REQ-034 Single request mshr_id=3, way=4'b0100, pld=8'hA5 accepted at edge t, resp_ready=1 -> resp_valid rises in cycle t+10 with fields 3/4'b0100/8'hA5, is high for 1 cycle, and outstanding returns to 0.
REQ-035 Back-to-back push of 8 requests with distinct ids and resp_ready=0 -> req_ready=0 after the 8th push, outstanding=8; then raise resp_ready -> 8 responses in order and req_ready returns to 1 after the first pop.
REQ-036 FIFO full with a simultaneous push attempt and head pop -> push refused (req_ready=0 in that cycle), outstanding drops to 7, and the push is accepted next cycle.
REQ-037 Push mshr_id=5 twice with no intervening pop -> dup_err=1, both responses still returned in order; push way=4'b0000 -> dup_err=1.
REQ-038 rst asserted asynchronously with 4 entries outstanding, mid-cycle -> resp_valid=0 and outstanding=0 immediately; after release a new request returns after exactly LATENCY cycles.
REQ-039 LATENCY=1 build, continuous push with resp_ready=1 -> one response per cycle, throughput 1, and outstanding stays at 1.

Source files
------------

// File: rtl/l1d_downstream_responder.sv
// rtl/l1d_downstream_responder.sv - fixed-latency in-order refill responder for L1D miss requests
// Requests are queued with a per-entry countdown; the head is offered once its countdown reaches zero.
module l1d_downstream_responder #(
    parameter int MSHR_ID_W = 4,
    parameter int WAY_NUM   = 4,
    parameter int PLD_W     = 8,
    parameter int DEPTH     = 8,
    parameter int LATENCY   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [MSHR_ID_W-1:0]      req_mshr_id,
    input  logic [WAY_NUM-1:0]        req_way,
    input  logic [PLD_W-1:0]          req_pld,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [MSHR_ID_W-1:0]      resp_mshr_id,
    output logic [WAY_NUM-1:0]        resp_way,
    output logic [PLD_W-1:0]          resp_pld,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      dup_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(LATENCY + 1);
    localparam int NID = 1 << MSHR_ID_W;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    logic [MSHR_ID_W-1:0] id_mem  [DEPTH];
    logic [WAY_NUM-1:0]   way_mem [DEPTH];
    logic [PLD_W-1:0]     pld_mem [DEPTH];
    logic [CW-1:0]        cnt_mem [DEPTH];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [NID-1:0] busy;
    logic [NID-1:0] busy_nxt;
    logic           push;
    logic           pop;
    logic           way_bad;
    logic           dup_hit;

    assign req_ready   = !rst && (count < FULL);
    assign resp_valid  = (count != '0) && (cnt_mem[rd_ptr] == '0);
    assign push        = req_valid && req_ready;
    assign pop         = resp_valid && resp_ready;
    assign outstanding = count;

    assign resp_mshr_id = resp_valid ? id_mem[rd_ptr]  : '0;
    assign resp_way     = resp_valid ? way_mem[rd_ptr] : '0;
    assign resp_pld     = resp_valid ? pld_mem[rd_ptr] : '0;

    // The pop clear is applied before the push set so a same-id swap leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[id_mem[rd_ptr]] = 1'b0;
        end
        if (push) begin
            busy_nxt[req_mshr_id] = 1'b1;
        end
    end

    assign way_bad = !$onehot(req_way);
    assign dup_hit = busy[req_mshr_id] && !(pop && (id_mem[rd_ptr] == req_mshr_id));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            busy    <= '0;
            dup_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            busy <= busy_nxt;
            if (push && (dup_hit || way_bad)) begin
                dup_err <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: a slot only matters after a push has loaded it.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]  <= req_mshr_id;
            way_mem[wr_ptr] <= req_way;
            pld_mem[wr_ptr] <= req_pld;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == AW'(i))) begin
                cnt_mem[i] <= CNT_LOAD;
            end else if (cnt_mem[i] != '0) begin
                cnt_mem[i] <= cnt_mem[i] - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_l1d_downstream_responder.sv
// tb/tb_l1d_downstream_responder.sv - self-checking bench for l1d_downstream_responder
module tb_l1d_downstream_responder;
    localparam int LAT   = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, dup_err;
    logic [3:0] req_mshr_id = '0, req_way = '0, resp_mshr_id, resp_way, outstanding;
    logic [7:0] req_pld = '0, resp_pld;

    logic       req_valid1 = 1'b0, req_ready1, resp_valid1, resp_ready1 = 1'b0, dup_err1;
    logic [3:0] req_mshr_id1 = '0, req_way1 = '0, resp_mshr_id1, resp_way1, outstanding1;
    logic [7:0] req_pld1 = '0, resp_pld1;

    l1d_downstream_responder #(.MSHR_ID_W(4), .WAY_NUM(4), .PLD_W(8), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mshr_id(req_mshr_id), .req_way(req_way), .req_pld(req_pld),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_mshr_id(resp_mshr_id),
        .resp_way(resp_way), .resp_pld(resp_pld), .outstanding(outstanding), .dup_err(dup_err)
    );

    l1d_downstream_responder #(.MSHR_ID_W(4), .WAY_NUM(4), .PLD_W(8), .DEPTH(DEPTH), .LATENCY(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_mshr_id(req_mshr_id1), .req_way(req_way1), .req_pld(req_pld1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_mshr_id(resp_mshr_id1),
        .resp_way(resp_way1), .resp_pld(resp_pld1), .outstanding(outstanding1), .dup_err(dup_err1)
    );

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    typedef struct {
        logic [3:0] id;
        logic [3:0] way;
        logic [7:0] pld;
        int         acc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mbusy;
    logic        mdup;

    // An entry accepted at edge n may be returned from the cycle after edge n+LAT-1 once it is oldest.
    function automatic bit m_valid();
        return (mq.size() != 0) && (mq[0].acc + LAT - 1 <= edge_n);
    endfunction

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mbusy <= '0;
            mdup  <= 1'b0;
        end else begin
            bit          vld;
            bit          rdy;
            bit          dup;
            logic [15:0] nb;
            vld = m_valid();
            rdy = (mq.size() < DEPTH);
            nb  = mbusy;
            dup = 1'b0;
            if (vld && resp_ready) begin
                nb[mq[0].id] = 1'b0;
                void'(mq.pop_front());
            end
            if (req_valid && rdy) begin
                dup = nb[req_mshr_id] || !$onehot(req_way);
                nb[req_mshr_id] = 1'b1;
                mq.push_back('{req_mshr_id, req_way, req_pld, edge_n + 1});
            end
            mbusy <= nb;
            if (dup) mdup <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [22:0] exp_v;
        logic [22:0] act_v;
        bit          v;
        v     = m_valid();
        exp_v = {!rst && (mq.size() < DEPTH), v, 4'(mq.size()), mdup,
                 v ? {mq[0].id, mq[0].way, mq[0].pld} : 16'h0};
        act_v = {req_ready, resp_valid, outstanding, dup_err, resp_mshr_id, resp_way, resp_pld};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL monitor t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
    end

    task automatic drive_req(input logic v, input logic [3:0] id, input logic [3:0] way, input logic [7:0] pld);
        req_valid = v; req_mshr_id = id; req_way = way; req_pld = pld;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (outstanding !== 4'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (outstanding !== 4'd0) begin failures++; $display("FAIL %s_drain outstanding=%0d required=0", name, outstanding); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b required=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", resp_valid); end
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL reset_outstanding actual=%0d required=0", outstanding); end
        checks++; if ({dup_err, resp_mshr_id, resp_way, resp_pld} !== 17'h0) begin
            failures++; $display("FAIL reset_fields actual=%h required=0", {dup_err, resp_mshr_id, resp_way, resp_pld});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready actual=%b required=1", req_ready); end
    endtask

    task automatic single_latency(input string name, input logic [3:0] id, input logic [3:0] way, input logic [7:0] pld);
        int          first = 0;
        int          nv = 0;
        logic [15:0] got = '0;
        @(negedge clk); #1;
        drive_req(1'b1, id, way, pld);
        resp_ready = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                nv++;
                if (first == 0) begin first = k; got = {resp_mshr_id, resp_way, resp_pld}; end
            end
            if (k == 1) begin #1 req_valid = 1'b0; end
        end
        checks++; if (first != LAT) begin failures++; $display("FAIL %s_latency actual=%0d required=%0d", name, first, LAT); end
        checks++; if (got !== {id, way, pld}) begin failures++; $display("FAIL %s_fields actual=%h required=%h", name, got, {id, way, pld}); end
        checks++; if (nv != 1) begin failures++; $display("FAIL %s_valid_cycles actual=%0d required=1", name, nv); end
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL %s_outstanding actual=%0d required=0", name, outstanding); end
    endtask

    task automatic test_single();
        single_latency("single", 4'd3, 4'b0100, 8'hA5);
    endtask

    task automatic fill_distinct(output logic [3:0] base, output logic [15:0] sent[8]);
        @(negedge clk); #1;
        resp_ready = 1'b0;
        base = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            sent[i] = {4'(i) ^ base, 4'(1 << $urandom_range(0, 3)), 8'($urandom)};
            drive_req(1'b1, sent[i][15:12], sent[i][11:8], sent[i][7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  base;
        logic [15:0] sent[8];
        fill_distinct(base, sent);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready actual=%b required=0", req_ready); end
        checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL b2b_full_count actual=%0d required=8", outstanding); end
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!resp_valid || {resp_mshr_id, resp_way, resp_pld} !== sent[i]) begin
                failures++;
                $display("FAIL b2b_order_%0d actual=%b/%h required=1/%h", i, resp_valid, {resp_mshr_id, resp_way, resp_pld}, sent[i]);
            end
            if (i == 0) begin #1 resp_ready = 1'b1; end
            @(negedge clk);
            if (i == 0) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop actual=%b required=1", req_ready); end
            end
        end
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL b2b_empty actual=%0d required=0", outstanding); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0]  base;
        logic [15:0] sent[8];
        logic [3:0]  new_id;
        logic [3:0]  last_id = '0;
        int          n = 0;
        fill_distinct(base, sent);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_refuse_ready actual=%b required=0", req_ready); end
        new_id = {~base[3], 3'($urandom)};
        #1;
        drive_req(1'b1, new_id, 4'b0010, 8'h5C);
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (outstanding !== 4'd7) begin failures++; $display("FAIL full_after_pop actual=%0d required=7", outstanding); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_next actual=%b required=1", req_ready); end
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL full_push_next actual=%0d required=8", outstanding); end
        #1 req_valid = 1'b0;
        resp_ready = 1'b1;
        while (outstanding !== 4'd0 && n < 100) begin
            @(negedge clk);
            if (resp_valid) last_id = resp_mshr_id;
            n++;
        end
        checks++; if (last_id !== new_id) begin failures++; $display("FAIL full_last_id actual=%h required=%h", last_id, new_id); end
        drain("full");
    endtask

    task automatic test_dup_id();
        logic [7:0] p1 = 8'($urandom);
        logic [7:0] p2 = 8'($urandom);
        logic [7:0] got[$];
        int         n = 0;
        @(negedge clk); #1;
        resp_ready = 1'b0;
        drive_req(1'b1, 4'd5, 4'b1000, p1);
        @(negedge clk);
        checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL dup_first actual=%b required=0", dup_err); end
        #1 drive_req(1'b1, 4'd5, 4'b0001, p2);
        @(negedge clk);
        checks++; if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_second actual=%b required=1", dup_err); end
        #1 req_valid = 1'b0;
        resp_ready = 1'b1;
        while (got.size() < 2 && n < 40) begin
            @(negedge clk);
            if (resp_valid) got.push_back(resp_pld);
            n++;
        end
        checks++;
        if (got.size() != 2 || got[0] !== p1 || got[1] !== p2) begin
            failures++; $display("FAIL dup_order actual_count=%0d required=2 p1=%h p2=%h", got.size(), p1, p2);
        end
        drain("dup");
    endtask

    task automatic test_reset_mid();
        @(negedge clk); #1;
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 4'(i + 8), 4'(1 << i), 8'($urandom));
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if ({resp_valid, outstanding} !== {1'b1, 4'd4}) begin
            failures++; $display("FAIL rstmid_pre actual=%b/%0d required=1/4", resp_valid, outstanding);
        end
        #3 rst = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid actual=%b required=0", resp_valid); end
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL rstmid_count actual=%0d required=0", outstanding); end
        checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL rstmid_dup actual=%b required=0", dup_err); end
        @(negedge clk);
        #1 rst = 1'b0;
        single_latency("rstmid", 4'($urandom), 4'b0001, 8'($urandom));
    endtask

    task automatic test_dup_way();
        @(negedge clk);
        checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL way_pre actual=%b required=0", dup_err); end
        #1 drive_req(1'b1, 4'd6, 4'b0000, 8'h11);
        @(negedge clk);
        checks++; if (dup_err !== 1'b1) begin failures++; $display("FAIL way_zero actual=%b required=1", dup_err); end
        checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL way_accepted actual=%0d required=1", outstanding); end
        #1 req_valid = 1'b0;
        resp_ready = 1'b1;
        drain("way");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            drive_req(1'($urandom), 4'($urandom),
                      ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3)),
                      8'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain("random");
    endtask

    task automatic test_latency1();
        logic [15:0] prev = '0;
        resp_ready1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if ({req_ready1, resp_valid1, outstanding1, resp_mshr_id1, resp_way1, resp_pld1} !== {1'b1, 1'b1, 4'd1, prev}) begin
                    failures++;
                    $display("FAIL lat1_cycle_%0d actual=%b/%b/%0d/%h required=1/1/1/%h", k, req_ready1, resp_valid1,
                             outstanding1, {resp_mshr_id1, resp_way1, resp_pld1}, prev);
                end
            end
            #1;
            prev = {4'($urandom), 4'(1 << $urandom_range(0, 3)), 8'($urandom)};
            req_valid1 = 1'b1;
            {req_mshr_id1, req_way1, req_pld1} = prev;
        end
        @(negedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        checks++; if (dup_err1 !== 1'b0) begin failures++; $display("FAIL lat1_dup actual=%b required=0", dup_err1); end
        checks++; if (outstanding1 !== 4'd0) begin failures++; $display("FAIL lat1_empty actual=%0d required=0", outstanding1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_push_pop();
        test_dup_id();
        test_reset_mid();
        test_dup_way();
        test_random();
        test_latency1();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
